// File: rtl/ex_operand_stage_if.sv
// Bundle of decode, forwarding-source and EX-side signals around the ID/EX operand stage.
// master = decode/pipeline control side, slave = ex_operand_stage.
interface ex_operand_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              id_valid;
    logic              id_regdst;
    logic              id_alusrc;
    logic              id_regwrite;
    logic              id_memread;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_read_data1;
    logic [DATA_W-1:0] id_read_data2;
    logic [DATA_W-1:0] id_imm;
    logic              stall_in;
    logic              flush;
    logic              mem_regwrite;
    logic [REG_AW-1:0] mem_destreg;
    logic [DATA_W-1:0] mem_aluout;
    logic              wb_regwrite;
    logic [REG_AW-1:0] wb_destreg;
    logic [DATA_W-1:0] wb_writedata;
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_destreg;
    logic [DATA_W-1:0] operand1;
    logic [DATA_W-1:0] operand2;
    logic [DATA_W-1:0] ex_store_data;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              hazard_stall;

    modport master (
        output id_valid, id_regdst, id_alusrc, id_regwrite, id_memread,
               id_rs, id_rt, id_rd, id_read_data1, id_read_data2, id_imm,
               stall_in, flush, mem_regwrite, mem_destreg, mem_aluout,
               wb_regwrite, wb_destreg, wb_writedata,
        input  ex_valid, ex_regwrite, ex_memread, ex_destreg, operand1, operand2,
               ex_store_data, forward_a, forward_b, hazard_stall
    );

    modport slave (
        input  id_valid, id_regdst, id_alusrc, id_regwrite, id_memread,
               id_rs, id_rt, id_rd, id_read_data1, id_read_data2, id_imm,
               stall_in, flush, mem_regwrite, mem_destreg, mem_aluout,
               wb_regwrite, wb_destreg, wb_writedata,
        output ex_valid, ex_regwrite, ex_memread, ex_destreg, operand1, operand2,
               ex_store_data, forward_a, forward_b, hazard_stall
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use detection, stall hold and flush bubble.
// Define EX_FWD_EN to build forwarding + stall capture; otherwise RAW hazards stall instead.
module ex_operand_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst_n,
    ex_operand_stage_if.slave bus
);
    logic                     vld_p1;
    logic                     regdst_p1;
    logic                     alusrc_p1;
    logic                     regwrite_p1;
    logic                     memread_p1;
    logic [REG_AW-1:0]        rs_p1;
    logic [REG_AW-1:0]        rt_p1;
    logic [REG_AW-1:0]        rd_p1;
    logic signed [DATA_W-1:0] data1_p1;
    logic signed [DATA_W-1:0] data2_p1;
    logic signed [DATA_W-1:0] imm_p1;

    logic [REG_AW-1:0]        destReg;
    logic [1:0]               fwdA;
    logic [1:0]               fwdB;
    logic signed [DATA_W-1:0] srcA;
    logic signed [DATA_W-1:0] srcB;
    logic                     hazard;

    // Register 0 never carries a real dependency when it is hardwired to zero.
    function automatic logic isLive(input logic [REG_AW-1:0] r);
        return !((ZERO_REG != 0) && (r == '0));
    endfunction

    assign destReg = regdst_p1 ? rd_p1 : rt_p1;

`ifdef EX_FWD_EN
    logic lockA_p1;
    logic lockB_p1;

    function automatic logic [1:0] fwdSel(
        input logic              vld,
        input logic              lock,
        input logic [REG_AW-1:0] src,
        input logic              memWr,
        input logic [REG_AW-1:0] memDst,
        input logic              wbWr,
        input logic [REG_AW-1:0] wbDst
    );
        if (!vld || lock || !isLive(src)) return 2'b00;
        if (memWr && (memDst == src))     return 2'b10;
        if (wbWr && (wbDst == src))       return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic signed [DATA_W-1:0] pickSrc(
        input logic [1:0]               sel,
        input logic signed [DATA_W-1:0] regData,
        input logic signed [DATA_W-1:0] memData,
        input logic signed [DATA_W-1:0] wbData
    );
        case (sel)
            2'b10:   return memData;
            2'b01:   return wbData;
            default: return regData;
        endcase
    endfunction

    always_comb begin
        fwdA = fwdSel(vld_p1, lockA_p1, rs_p1, bus.mem_regwrite, bus.mem_destreg,
                      bus.wb_regwrite, bus.wb_destreg);
        fwdB = fwdSel(vld_p1, lockB_p1, rt_p1, bus.mem_regwrite, bus.mem_destreg,
                      bus.wb_regwrite, bus.wb_destreg);
        srcA = pickSrc(fwdA, data1_p1, bus.mem_aluout, bus.wb_writedata);
        srcB = pickSrc(fwdB, data2_p1, bus.mem_aluout, bus.wb_writedata);
    end

    // Only a load in EX is a hazard; everything else resolves through MEM/WB forwarding.
    assign hazard = vld_p1 & memread_p1 & bus.id_valid & isLive(destReg) &
                    ((destReg == bus.id_rs) | (destReg == bus.id_rt));
`else
    logic exWrites;
    logic memWrites;
    logic unusedFwd;

    assign fwdA = 2'b00;
    assign fwdB = 2'b00;
    assign srcA = data1_p1;
    assign srcB = data2_p1;

    // Register file writes before it reads, so only EX and MEM producers need a stall.
    assign exWrites  = vld_p1 & regwrite_p1 & isLive(destReg) &
                       ((destReg == bus.id_rs) | (destReg == bus.id_rt));
    assign memWrites = bus.mem_regwrite & isLive(bus.mem_destreg) &
                       ((bus.mem_destreg == bus.id_rs) | (bus.mem_destreg == bus.id_rt));
    assign hazard    = bus.id_valid & (exWrites | memWrites);
    assign unusedFwd = ^{bus.mem_aluout, bus.wb_regwrite, bus.wb_destreg, bus.wb_writedata};
`endif

    // ID -> EX register stage
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush || (hazard && !bus.stall_in)) begin
            vld_p1      <= 1'b0;
            regdst_p1   <= 1'b0;
            alusrc_p1   <= 1'b0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
            data1_p1    <= '0;
            data2_p1    <= '0;
            imm_p1      <= '0;
`ifdef EX_FWD_EN
            lockA_p1    <= 1'b0;
            lockB_p1    <= 1'b0;
`endif
        end else if (bus.stall_in) begin
`ifdef EX_FWD_EN
            // A producer may retire during the hold; keep its value and stop re-selecting.
            if (fwdA != 2'b00) begin
                data1_p1 <= srcA;
                lockA_p1 <= 1'b1;
            end
            if (fwdB != 2'b00) begin
                data2_p1 <= srcB;
                lockB_p1 <= 1'b1;
            end
`endif
        end else begin
            vld_p1      <= bus.id_valid;
            regdst_p1   <= bus.id_regdst;
            alusrc_p1   <= bus.id_alusrc;
            regwrite_p1 <= bus.id_regwrite;
            memread_p1  <= bus.id_memread;
            rs_p1       <= bus.id_rs;
            rt_p1       <= bus.id_rt;
            rd_p1       <= bus.id_rd;
            data1_p1    <= bus.id_read_data1;
            data2_p1    <= bus.id_read_data2;
            imm_p1      <= bus.id_imm;
`ifdef EX_FWD_EN
            lockA_p1    <= 1'b0;
            lockB_p1    <= 1'b0;
`endif
        end
    end

    // EX outputs (combinational from the ID/EX register and forwarding sources)
    assign bus.ex_valid      = vld_p1;
    assign bus.ex_regwrite   = vld_p1 & regwrite_p1;
    assign bus.ex_memread    = vld_p1 & memread_p1;
    assign bus.ex_destreg    = destReg;
    assign bus.operand1      = srcA;
    assign bus.operand2      = alusrc_p1 ? imm_p1 : srcB;
    assign bus.ex_store_data = srcB;
    assign bus.forward_a     = fwdA;
    assign bus.forward_b     = fwdB;
    assign bus.hazard_stall  = hazard;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage; follows EX_FWD_EN so the same file covers both builds.
module tb_ex_operand_stage;
    logic clk;
    logic rst_n;

    ex_operand_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

    ex_operand_stage #(.DATA_W(16), .REG_AW(3), .ZERO_REG(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [58:0] val;
    } expT;

    expT q[$];
    int  tests = 0;
    int  fails = 0;

    // Monitor: outputs are settled mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            expT e;
            logic [58:0] act;
            e   = q.pop_front();
            act = {bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_destreg,
                   bus.operand1, bus.operand2, bus.ex_store_data,
                   bus.forward_a, bus.forward_b, bus.hazard_stall};
            tests++;
            if (act !== e.val) begin
                fails++;
                $display("FAIL %s: got v=%b rw=%b mr=%b dst=%0d op1=%h op2=%h sd=%h fa=%b fb=%b hz=%b, expected %h (packed), got %h",
                         e.name, act[58], act[57], act[56], act[55:53], act[52:37], act[36:21],
                         act[20:5], act[4:3], act[2:1], act[0], e.val, act);
            end
        end
    end

    task automatic expect_out(input string nm, input logic v, input logic rw, input logic mr,
                              input logic [2:0] d, input logic [15:0] o1, input logic [15:0] o2,
                              input logic [15:0] sd, input logic [1:0] fa, input logic [1:0] fb,
                              input logic hz);
        expT e;
        e.name = nm;
        e.val  = {v, rw, mr, d, o1, o2, sd, fa, fb, hz};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic regdst, input logic alusrc, input logic rw,
                         input logic mr, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic [15:0] d1, input logic [15:0] d2,
                         input logic [15:0] imm);
        bus.id_valid      = v;
        bus.id_regdst     = regdst;
        bus.id_alusrc     = alusrc;
        bus.id_regwrite   = rw;
        bus.id_memread    = mr;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.id_read_data1 = d1;
        bus.id_read_data2 = d2;
        bus.id_imm        = imm;
    endtask

    task automatic setFwd(input logic mrw, input logic [2:0] mdst, input logic [15:0] mval,
                          input logic wrw, input logic [2:0] wdst, input logic [15:0] wval);
        bus.mem_regwrite = mrw;
        bus.mem_destreg  = mdst;
        bus.mem_aluout   = mval;
        bus.wb_regwrite  = wrw;
        bus.wb_destreg   = wdst;
        bus.wb_writedata = wval;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.stall_in = 1'b0;
        bus.flush    = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        setFwd(0, 0, 16'h0, 0, 0, 16'h0);
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        rst_n = 1'b1;
        setId(1, 0, 0, 1, 0, 3'd1, 3'd2, 3'd4, 16'h1111, 16'h2222, 16'h0);
        tick();
`ifdef EX_FWD_EN
        setFwd(1, 3'd1, 16'hAAAA, 1, 3'd1, 16'hBBBB);
        expect_out("fwd_mem_prio", 1, 1, 0, 2, 16'hAAAA, 16'h2222, 16'h2222, 2'b10, 2'b00, 0);
        tick();
        bus.mem_regwrite = 1'b0;
        setId(1, 1, 1, 1, 0, 3'd3, 3'd1, 3'd2, 16'h3333, 16'h4444, 16'hFFFF);
        expect_out("fwd_wb", 1, 1, 0, 2, 16'hBBBB, 16'h2222, 16'h2222, 2'b01, 2'b00, 0);
        tick();
        bus.mem_regwrite = 1'b1;
        setId(1, 0, 1, 1, 1, 3'd0, 3'd3, 3'd0, 16'h0, 16'h0, 16'h0010);
        expect_out("alusrc_regdst", 1, 1, 0, 2, 16'h3333, 16'hFFFF, 16'hAAAA, 2'b00, 2'b10, 0);
        tick();
        setFwd(0, 0, 16'h0, 0, 0, 16'h0);
        setId(1, 1, 0, 1, 0, 3'd3, 3'd5, 3'd6, 16'h7777, 16'h5050, 16'h0);
        expect_out("load_use_hz", 1, 1, 1, 3, 16'h0, 16'h0010, 16'h0, 2'b00, 2'b00, 1);
        tick();
        setFwd(1, 3'd3, 16'hCAFE, 0, 0, 16'h0);
        expect_out("bubble", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
        setId(1, 0, 0, 1, 0, 3'd4, 3'd2, 3'd0, 16'h4040, 16'h2020, 16'h0);
        expect_out("load_use_fwd", 1, 1, 0, 6, 16'hCAFE, 16'h5050, 16'h5050, 2'b10, 2'b00, 0);
        tick();
        setFwd(0, 0, 16'h0, 1, 3'd2, 16'h1234);
        bus.stall_in = 1'b1;
        expect_out("stall_cap0", 1, 1, 0, 2, 16'h4040, 16'h1234, 16'h1234, 2'b00, 2'b01, 0);
        tick();
        bus.wb_writedata = 16'h5555;
        expect_out("stall_cap1", 1, 1, 0, 2, 16'h4040, 16'h1234, 16'h1234, 2'b00, 2'b00, 0);
        tick();
        expect_out("stall_cap2", 1, 1, 0, 2, 16'h4040, 16'h1234, 16'h1234, 2'b00, 2'b00, 0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;
        setFwd(0, 0, 16'h0, 1, 3'd2, 16'h1234);
        setId(1, 0, 0, 1, 0, 3'd1, 3'd2, 3'd0, 16'h0101, 16'h0202, 16'h0);
        expect_out("flush_stall", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
        bus.stall_in = 1'b1;
        expect_out("rst_pre", 1, 1, 0, 2, 16'h0101, 16'h1234, 16'h1234, 2'b00, 2'b01, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_out("rst_mid_stall", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
        bus.stall_in = 1'b0;
        setId(1, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 16'h1357, 16'h2468, 16'h0);
        tick();
        setFwd(1, 3'd0, 16'hAAAA, 1, 3'd0, 16'hBBBB);
        setId(1, 0, 0, 1, 1, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        expect_out("zero_reg", 1, 1, 0, 0, 16'h1357, 16'h2468, 16'h2468, 2'b00, 2'b00, 0);
        tick();
        setFwd(0, 0, 16'h0, 0, 0, 16'h0);
        setId(1, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        expect_out("zero_load_nohz", 1, 1, 1, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
`else
        setFwd(1, 3'd1, 16'hAAAA, 1, 3'd1, 16'hBBBB);
        setId(1, 0, 1, 0, 0, 3'd5, 3'd6, 3'd0, 16'h5555, 16'h6666, 16'hFFFF);
        expect_out("nofwd_regfile", 1, 1, 0, 2, 16'h1111, 16'h2222, 16'h2222, 2'b00, 2'b00, 0);
        tick();
        setFwd(1, 3'd3, 16'hAAAA, 0, 0, 16'h0);
        setId(1, 1, 0, 1, 0, 3'd3, 3'd0, 3'd7, 16'h3030, 16'h0, 16'h0);
        expect_out("hz_mem", 1, 0, 0, 6, 16'h5555, 16'hFFFF, 16'h6666, 2'b00, 2'b00, 1);
        tick();
        setFwd(0, 0, 16'h0, 0, 0, 16'h0);
        expect_out("nofwd_bubble", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
        setId(1, 0, 0, 1, 0, 3'd7, 3'd1, 3'd0, 16'h0F0F, 16'h1010, 16'h0);
        bus.stall_in = 1'b1;
        expect_out("hz_ex", 1, 1, 0, 7, 16'h3030, 16'h0, 16'h0, 2'b00, 2'b00, 1);
        tick();
        expect_out("stall_over_hz", 1, 1, 0, 7, 16'h3030, 16'h0, 16'h0, 2'b00, 2'b00, 1);
        tick();
        bus.stall_in = 1'b0;
        setFwd(1, 3'd0, 16'hAAAA, 0, 0, 16'h0);
        setId(1, 0, 0, 1, 0, 3'd0, 3'd0, 3'd0, 16'h1357, 16'h2468, 16'h0);
        expect_out("zero_reg_nohz", 1, 1, 0, 7, 16'h3030, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
        bus.flush    = 1'b1;
        bus.stall_in = 1'b1;
        expect_out("zero_reg_data", 1, 1, 0, 0, 16'h1357, 16'h2468, 16'h2468, 2'b00, 2'b00, 0);
        tick();
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;
        setFwd(0, 0, 16'h0, 0, 0, 16'h0);
        expect_out("flush_stall", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        setId(1, 1, 0, 1, 0, 3'd1, 3'd2, 3'd3, 16'h0101, 16'h0202, 16'h0);
        tick();
        bus.stall_in = 1'b1;
        expect_out("rst_pre", 1, 1, 0, 3, 16'h0101, 16'h0202, 16'h0202, 2'b00, 2'b00, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_out("rst_mid_stall", 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 0);
        tick();
        bus.stall_in = 1'b0;
        setId(1, 1, 1, 1, 0, 3'd4, 3'd5, 3'd2, 16'h4444, 16'h5555, 16'hFFFF);
        tick();
        bus.id_valid = 1'b0;
        expect_out("alusrc_regdst", 1, 1, 0, 2, 16'h4444, 16'hFFFF, 16'h5555, 2'b00, 2'b00, 0);
        tick();
`endif
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
